cpu_controller: RTL and testbench

CPU_CONTROLLER -- requirements
Module: cpu_controller

---
 rtl/cpu_controller.sv | 165 ++++++++++++++++
 tb/tb_cpu_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/writeback control for a small datapath.
// Optional CTRL_TIMEOUT_EN adds an EXEC watchdog that traps to FAULT after TIMEOUT stalled cycles.
module cpu_controller #(
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] instr,
  input  logic        en_out,
  output logic        en_pc,
  output logic        en_in,
  output logic [1:0]  pc_ctrl,
  output logic [7:0]  offset,
  output logic [1:0]  rd,
  output logic [1:0]  rs,
  output logic [2:0]  alu_func,
  output logic        alu_in_sel,
  output logic [3:0]  reg_en,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [15:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_JMP, S_INC, S_HALT, S_FAULT
  } state_t;

  localparam logic [3:0] OP_MOVB = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_JUMP = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("cpu_controller: TIMEOUT must be in 1..255");
  end

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;
  logic [15:0] r_retired;
  logic [3:0]  w_op;

  assign w_op = r_ir[15:12];

`ifdef CTRL_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;
  logic       w_tmo_hit;

  // Holds the number of stalled EXEC cycles already seen; zero whenever EXEC is entered.
  assign w_tmo_hit = (r_tmo_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst)
      r_tmo_cnt <= 8'd0;
    else if (r_state == S_EXEC && !en_out && !w_tmo_hit)
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    else
      r_tmo_cnt <= 8'd0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ir      <= 16'h0000;
      r_retired <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH)
        r_ir <= instr;
      if (r_state == S_WB || r_state == S_JMP || r_state == S_INC)
        r_retired <= r_retired + 16'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_MOVB, OP_ADD, OP_SUB, OP_AND, OP_OR: w_next = S_EXEC;
          OP_JUMP: w_next = S_JMP;
          OP_HALT: w_next = S_HALT;
          default: w_next = S_INC;
        endcase
      end
      S_EXEC: begin
        // A ready result on the final allowed cycle still completes normally.
        if (en_out)
          w_next = S_WB;
`ifdef CTRL_TIMEOUT_EN
        else if (w_tmo_hit)
          w_next = S_FAULT;
`endif
      end
      S_WB, S_JMP, S_INC: w_next = S_FETCH;
      S_HALT:  if (start) w_next = S_INC;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_IDLE;
    endcase
  end

  assign offset  = r_ir[7:0];
  assign rd      = r_ir[11:10];
  assign rs      = r_ir[9:8];
  assign retired = r_retired;

  always_comb begin
    alu_func   = 3'b000;
    alu_in_sel = 1'b0;
    case (w_op)
      OP_ADD: begin alu_func = 3'b001; alu_in_sel = 1'b1; end
      OP_SUB: begin alu_func = 3'b010; alu_in_sel = 1'b1; end
      OP_AND: begin alu_func = 3'b011; alu_in_sel = 1'b1; end
      OP_OR:  begin alu_func = 3'b100; alu_in_sel = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    en_pc   = 1'b0;
    en_in   = 1'b0;
    pc_ctrl = 2'b00;
    reg_en  = 4'b0000;
    busy    = 1'b0;
    halted  = 1'b0;
    fault   = 1'b0;
    case (r_state)
      S_FETCH, S_DECODE: busy = 1'b1;
      S_EXEC: begin
        busy  = 1'b1;
        en_in = 1'b1;
      end
      S_WB: begin
        busy    = 1'b1;
        en_pc   = 1'b1;
        pc_ctrl = 2'b01;
        reg_en  = 4'b0001 << rd;
      end
      S_JMP: begin
        busy    = 1'b1;
        en_pc   = 1'b1;
        pc_ctrl = 2'b10;
      end
      S_INC: begin
        busy    = 1'b1;
        en_pc   = 1'b1;
        pc_ctrl = 2'b01;
      end
      S_HALT: halted = 1'b1;
`ifdef CTRL_TIMEOUT_EN
      S_FAULT: fault = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: reset, ALU ops, jump, halt/resume, NOP, timeout, mid-op reset.
module tb_cpu_controller;
  logic        clk = 1'b0;
  logic        rst, start, en_out;
  logic [15:0] instr;
  logic        en_pc, en_in, alu_in_sel, busy, halted, fault;
  logic [1:0]  pc_ctrl, rd, rs;
  logic [7:0]  offset;
  logic [2:0]  alu_func;
  logic [3:0]  reg_en;
  logic [15:0] retired;
  int n_cmp = 0;
  int n_err = 0;

  cpu_controller #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .en_out(en_out),
    .en_pc(en_pc), .en_in(en_in), .pc_ctrl(pc_ctrl), .offset(offset), .rd(rd), .rs(rs),
    .alu_func(alu_func), .alu_in_sel(alu_in_sel), .reg_en(reg_en),
    .busy(busy), .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  // Output bundle: {en_pc, en_in, pc_ctrl, reg_en, alu_func, alu_in_sel, busy, halted, fault}
  function automatic logic [15:0] outs();
    return {en_pc, en_in, pc_ctrl, reg_en, alu_func, alu_in_sel, busy, halted, fault};
  endfunction

  function automatic logic [15:0] eo(logic pc, logic in, logic [1:0] pcc, logic [3:0] re,
                                     logic [2:0] f, logic sel, logic b, logic h, logic flt);
    return {pc, in, pcc, re, f, sel, b, h, flt};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; step(); rst = 1'b1; step();
  endtask

  // Enter with the controller in FETCH; leaves it in FETCH after writeback.
  task automatic do_alu(input logic [15:0] ins, input logic [2:0] f, input logic sel,
                        input logic [3:0] re, input int n, input logic hold_start);
    instr = ins; step();
    n_cmp++; if (outs() !== eo(0,0,2'b00,4'b0,f,sel,1,0,0)) begin n_err++;
      $display("FAIL alu_decode ins=%h got=%h exp=%h", ins, outs(), eo(0,0,2'b00,4'b0,f,sel,1,0,0)); end
    n_cmp++; if ({rd, rs, offset} !== ins[11:0]) begin n_err++;
      $display("FAIL alu_fields ins=%h got=%h exp=%h", ins, {rd, rs, offset}, ins[11:0]); end
    start = hold_start;
    step();
    for (int i = 0; i < n; i++) begin
      n_cmp++; if (outs() !== eo(0,1,2'b00,4'b0,f,sel,1,0,0)) begin n_err++;
        $display("FAIL alu_exec ins=%h cyc=%0d got=%h exp=%h", ins, i, outs(), eo(0,1,2'b00,4'b0,f,sel,1,0,0)); end
      if (i == n - 1) en_out = 1'b1;
      step();
    end
    en_out = 1'b0; start = 1'b0;
    n_cmp++; if (outs() !== eo(1,0,2'b01,re,f,sel,1,0,0)) begin n_err++;
      $display("FAIL alu_wb ins=%h got=%h exp=%h", ins, outs(), eo(1,0,2'b01,re,f,sel,1,0,0)); end
    step();
    n_cmp++; if (outs() !== eo(0,0,2'b00,4'b0,f,sel,1,0,0)) begin n_err++;
      $display("FAIL alu_refetch ins=%h got=%h exp=%h", ins, outs(), eo(0,0,2'b00,4'b0,f,sel,1,0,0)); end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; en_out = 1'b0; instr = 16'h2400;
    step(); step();
    n_cmp++; if ({outs(), offset, rd, rs, retired} !== 44'h0) begin n_err++;
      $display("FAIL reset_outs got=%h exp=0", {outs(), offset, rd, rs, retired}); end
    rst = 1'b1; start = 1'b0; step(); step();
    n_cmp++; if (outs() !== 16'h0) begin n_err++;
      $display("FAIL idle_hold got=%h exp=0", outs()); end
  endtask

  task automatic test_movb();
    instr = 16'h1001; start = 1'b1; step(); start = 1'b0;
    n_cmp++; if (outs() !== eo(0,0,2'b00,4'b0,3'b000,0,1,0,0)) begin n_err++;
      $display("FAIL movb_fetch got=%h exp=%h", outs(), eo(0,0,2'b00,4'b0,3'b000,0,1,0,0)); end
    do_alu(16'h1001, 3'b000, 1'b0, 4'b0001, 4, 1'b0);
    n_cmp++; if (retired !== 16'd1) begin n_err++;
      $display("FAIL movb_retired got=%0d exp=1", retired); end
  endtask

  task automatic test_alu();
    do_reset();
    instr = 16'h2400; start = 1'b1; step(); start = 1'b0;
    do_alu(16'h2400, 3'b001, 1'b1, 4'b0010, 1, 1'b0);
    do_alu(16'h3400, 3'b010, 1'b1, 4'b0010, 2, 1'b1);
    do_alu(16'h4400, 3'b011, 1'b1, 4'b0010, 3, 1'b0);
    do_alu(16'h5400, 3'b100, 1'b1, 4'b0010, 1, 1'b0);
    n_cmp++; if (retired !== 16'd4) begin n_err++;
      $display("FAIL alu_retired got=%0d exp=4", retired); end
    do_alu(16'h1F00, 3'b000, 1'b0, 4'b1000, 1, 1'b0);
  endtask

  task automatic test_jump();
    instr = 16'h6078; step(); step();
    n_cmp++; if (outs() !== eo(1,0,2'b10,4'b0,3'b000,0,1,0,0)) begin n_err++;
      $display("FAIL jmp_outs got=%h exp=%h", outs(), eo(1,0,2'b10,4'b0,3'b000,0,1,0,0)); end
    n_cmp++; if (offset !== 8'h78) begin n_err++;
      $display("FAIL jmp_offset got=%h exp=78", offset); end
    step();
    n_cmp++; if (outs() !== eo(0,0,2'b00,4'b0,3'b000,0,1,0,0)) begin n_err++;
      $display("FAIL jmp_refetch got=%h exp=%h", outs(), eo(0,0,2'b00,4'b0,3'b000,0,1,0,0)); end
    n_cmp++; if (retired !== 16'd6) begin n_err++;
      $display("FAIL jmp_retired got=%0d exp=6", retired); end
  endtask

  task automatic test_halt_nop();
    instr = 16'hF000; step(); step(); step();
    n_cmp++; if (outs() !== eo(0,0,2'b00,4'b0,3'b000,0,0,1,0)) begin n_err++;
      $display("FAIL halt_outs got=%h exp=%h", outs(), eo(0,0,2'b00,4'b0,3'b000,0,0,1,0)); end
    start = 1'b1; step(); start = 1'b0;
    n_cmp++; if (outs() !== eo(1,0,2'b01,4'b0,3'b000,0,1,0,0)) begin n_err++;
      $display("FAIL halt_resume_inc got=%h exp=%h", outs(), eo(1,0,2'b01,4'b0,3'b000,0,1,0,0)); end
    step();
    n_cmp++; if (outs() !== eo(0,0,2'b00,4'b0,3'b000,0,1,0,0)) begin n_err++;
      $display("FAIL halt_refetch got=%h exp=%h", outs(), eo(0,0,2'b00,4'b0,3'b000,0,1,0,0)); end
    instr = 16'h7000; step(); step();
    n_cmp++; if (outs() !== eo(1,0,2'b01,4'b0,3'b000,0,1,0,0)) begin n_err++;
      $display("FAIL nop_inc got=%h exp=%h", outs(), eo(1,0,2'b01,4'b0,3'b000,0,1,0,0)); end
    step();
    n_cmp++; if (retired !== 16'd8) begin n_err++;
      $display("FAIL nop_retired got=%0d exp=8", retired); end
  endtask

  task automatic test_timeout();
    instr = 16'h2400; step(); step();
`ifdef CTRL_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (outs() !== eo(0,1,2'b00,4'b0,3'b001,1,1,0,0)) begin n_err++;
        $display("FAIL tmo_exec cyc=%0d got=%h", i, outs()); end
      step();
    end
    start = 1'b1; en_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (outs() !== eo(0,0,2'b00,4'b0,3'b001,1,0,0,1)) begin n_err++;
        $display("FAIL tmo_fault cyc=%0d got=%h exp=%h", i, outs(), eo(0,0,2'b00,4'b0,3'b001,1,0,0,1)); end
      step();
    end
    start = 1'b0; en_out = 1'b0;
    do_reset();
    n_cmp++; if (outs() !== 16'h0) begin n_err++;
      $display("FAIL tmo_reset got=%h exp=0", outs()); end
    instr = 16'h2400; start = 1'b1; step(); start = 1'b0;
    do_alu(16'h2400, 3'b001, 1'b1, 4'b0010, 8, 1'b0);
`else
    for (int i = 0; i < 120; i++) begin
      n_cmp++; if (outs() !== eo(0,1,2'b00,4'b0,3'b001,1,1,0,0)) begin n_err++;
        $display("FAIL noto_exec cyc=%0d got=%h", i, outs()); end
      step();
    end
    en_out = 1'b1; step(); en_out = 1'b0;
    n_cmp++; if (outs() !== eo(1,0,2'b01,4'b0010,3'b001,1,1,0,0)) begin n_err++;
      $display("FAIL noto_wb got=%h exp=%h", outs(), eo(1,0,2'b01,4'b0010,3'b001,1,1,0,0)); end
    step();
`endif
  endtask

  task automatic test_reset_mid();
    instr = 16'h5C00; step(); step();
    n_cmp++; if (en_in !== 1'b1) begin n_err++;
      $display("FAIL mid_pre_exec got=%b exp=1", en_in); end
    rst = 1'b0; step();
    n_cmp++; if ({outs(), offset, rd, rs, retired} !== 44'h0) begin n_err++;
      $display("FAIL mid_exec_reset got=%h exp=0", {outs(), offset, rd, rs, retired}); end
    rst = 1'b1; step();
    instr = 16'h1C00; start = 1'b1; step(); start = 1'b0;
    step(); step(); en_out = 1'b1; step(); en_out = 1'b0;
    n_cmp++; if (reg_en !== 4'b1000) begin n_err++;
      $display("FAIL mid_pre_wb got=%b exp=1000", reg_en); end
    rst = 1'b0; step();
    n_cmp++; if ({outs(), retired} !== 32'h0) begin n_err++;
      $display("FAIL mid_wb_reset got=%h exp=0", {outs(), retired}); end
    rst = 1'b1; step();
    n_cmp++; if (outs() !== 16'h0) begin n_err++;
      $display("FAIL mid_after_reset got=%h exp=0", outs()); end
  endtask

  initial begin
    test_reset();
    test_movb();
    test_alu();
    test_jump();
    test_halt_nop();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
